// File: rtl/ifu_pkg.sv
// +----------------------------------------------------------------------------+
// | ifu_pkg : shared widths, NOP encoding, FSM states and fetch-entry type     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package ifu_pkg;

  localparam int PC_WIDTH    = 32;
  localparam int INSTR_WIDTH = 32;

  localparam logic [INSTR_WIDTH-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

  function automatic logic [PC_WIDTH-1:0] word_align(input logic [PC_WIDTH-1:0] a);
    return a & ~PC_WIDTH'(3);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ifu_if.sv
// +----------------------------------------------------------------------------+
// | ifu_if : instruction bus (req/gnt request phase, in-order rvalid response) |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface ifu_if;
  import ifu_pkg::*;

  logic                   req;
  logic [PC_WIDTH-1:0]    addr;
  logic                   gnt;
  logic                   rvalid;
  logic [INSTR_WIDTH-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

`default_nettype wire

// File: rtl/ifu_fifo.sv
// +----------------------------------------------------------------------------+
// | ifu_fifo : synchronous {pc,instr} fetch buffer with flush; head is direct  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  input  wire logic                   push_i,
  input  wire fetch_entry_t           push_data_i,
  input  wire logic                   pop_i,
  input  wire logic                   flush_i,
  output fetch_entry_t                head_o,
  output logic [$clog2(DEPTH):0]      count_o,
  output logic                        empty_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Storage needs no reset: the head is only consumed while count is nonzero.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/ifu.sv
// +----------------------------------------------------------------------------+
// | ifu : instruction fetch unit (PC gen, bus issue, redirect drain, buffer)   |
// | Optional perf counters with IFU_PERF_CNT_EN.                  Rev 1.0      |
// +----------------------------------------------------------------------------+
`default_nettype none

module ifu
  import ifu_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                  FIFO_DEPTH = 2
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  input  wire logic                   stall_i,
  input  wire logic                   jump_i,
  input  wire logic [PC_WIDTH-1:0]    jump_addr_i,
  ifu_if.master                       ibus,
  output logic [PC_WIDTH-1:0]         if_pc_o,
  output logic [INSTR_WIDTH-1:0]      if_instr_o,
  output logic                        if_valid_o
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]                 perf_fetch_cnt_o,
  output logic [31:0]                 perf_bubble_cnt_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  ifu_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]       outst_q, outst_d;

  fetch_entry_t        w_head;
  fetch_entry_t        w_push_data;
  logic [CW-1:0]       w_fifo_count;
  logic                w_fifo_empty;
  logic [CW:0]         w_inflight;
  logic                w_req, w_issue, w_retire, w_resp_ok;
  logic                w_valid, w_fire, w_push, w_pop, w_flush;
  logic [PC_WIDTH-1:0] w_target;

  // Buffer space is reserved at issue time, so a returning word always fits.
  assign w_inflight = {1'b0, outst_q} + {1'b0, w_fifo_count};
  assign w_req      = (state_q == ST_RUN) && !jump_i && (w_inflight < DEPTH_C);
  assign w_issue    = w_req && ibus.gnt;
  assign w_retire   = ibus.rvalid && (outst_q != '0);
  assign w_resp_ok  = w_retire && (state_q == ST_RUN) && !jump_i;
  assign w_target   = word_align(jump_addr_i);

  assign ibus.req   = w_req;
  assign ibus.addr  = fetch_pc_q;

  always_comb begin
    outst_d = outst_q;
    case ({w_issue, w_retire})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    w_flush    = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (jump_i) begin
          fetch_pc_d = w_target;
          resp_pc_d  = w_target;
          w_flush    = 1'b1;
          if (outst_d != '0) state_d = ST_DRAIN;
        end else begin
          if (w_issue)   fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
          if (w_resp_ok) resp_pc_d  = resp_pc_q + PC_WIDTH'(4);
        end
      end
      ST_DRAIN: begin
        // Wrong-path responses are discarded; nothing is issued until they are all back.
        if (jump_i) begin
          fetch_pc_d = w_target;
          resp_pc_d  = w_target;
        end
        if (outst_d == '0) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
    end
  end

  // An empty buffer forwards the arriving word so a zero-wait bus gives 1 instr/cycle.
  always_comb begin
    w_valid    = 1'b0;
    if_pc_o    = fetch_pc_q;
    if_instr_o = INSTR_NOP;
    if (!jump_i) begin
      if (!w_fifo_empty) begin
        w_valid    = 1'b1;
        if_pc_o    = w_head.pc;
        if_instr_o = w_head.instr;
      end else if (w_resp_ok) begin
        w_valid    = 1'b1;
        if_pc_o    = resp_pc_q;
        if_instr_o = ibus.rdata;
      end
    end
  end

  assign if_valid_o        = w_valid;
  assign w_fire            = w_valid && !stall_i;
  assign w_pop             = w_fire && !w_fifo_empty;
  assign w_push            = w_resp_ok && !(w_fifo_empty && w_fire);
  assign w_push_data.pc    = resp_pc_q;
  assign w_push_data.instr = ibus.rdata;

  ifu_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (w_push),
    .push_data_i (w_push_data),
    .pop_i       (w_pop),
    .flush_i     (w_flush),
    .head_o      (w_head),
    .count_o     (w_fifo_count),
    .empty_o     (w_fifo_empty)
  );

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_bubble_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q  <= '0;
      perf_bubble_q <= '0;
    end else begin
      if (w_fire)               perf_fetch_q  <= perf_fetch_q + 32'd1;
      if (!stall_i && !w_valid) perf_bubble_q <= perf_bubble_q + 32'd1;
    end
  end

  assign perf_fetch_cnt_o  = perf_fetch_q;
  assign perf_bubble_cnt_o = perf_bubble_q;
`endif

endmodule

`default_nettype wire
